// File: rtl/rename_unit.sv
// Single-issue register-rename stage: RAT lookup, free-list allocation, ready-table
// tracking and ROB index allocation, with a one-cycle registered output.
module rename_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int ROB_DEPTH = 16,
    parameter int AREG_W    = $clog2(ARCH_REGS),
    parameter int PREG_W    = $clog2(PHYS_REGS),
    parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AREG_W-1:0] sr1,
    input  logic [AREG_W-1:0] sr2,
    input  logic [AREG_W-1:0] dr,
    input  logic              has_dest,
    input  logic [3:0]        aluOp,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] sr1_p,
    output logic [PREG_W-1:0] sr2_p,
    output logic [PREG_W-1:0] dr_p,
    output logic [PREG_W-1:0] old_dr_p,
    output logic              s1_ready,
    output logic              s2_ready,
    output logic [3:0]        aluOp_out,
    output logic [31:0]       imm_out,
    output logic [ROB_W-1:0]  ROB_num,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_preg,
    input  logic              commit_valid,
    input  logic              commit_has_dest,
    input  logic [PREG_W-1:0] commit_old_preg
);

    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FL_W     = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam logic [FL_W:0]  FL_FULL  = (FL_W + 1)'(FL_DEPTH);
    localparam logic [ROB_W:0] ROB_FULL = (ROB_W + 1)'(ROB_DEPTH);

    logic [PREG_W-1:0]    rat     [ARCH_REGS];
    logic [PHYS_REGS-1:0] ready_tbl;
    logic [PREG_W-1:0]    fl_mem  [FL_DEPTH];
    logic [FL_W-1:0]      fl_head;
    logic [FL_W-1:0]      fl_tail;
    logic [FL_W:0]        fl_count;
    logic [ROB_W-1:0]     rob_tail;
    logic [ROB_W:0]       rob_count;

    logic              need_alloc;
    logic              accept;
    logic              do_alloc;
    logic              fl_push;
    logic [PREG_W-1:0] alloc_preg;
    logic [PREG_W-1:0] src1_p;
    logic [PREG_W-1:0] src2_p;
    logic              src1_rdy;
    logic              src2_rdy;

    function automatic logic [FL_W-1:0] fl_next(input logic [FL_W-1:0] p);
        return (p == FL_W'(FL_DEPTH - 1)) ? '0 : p + FL_W'(1);
    endfunction

    // Capacity checks use this cycle's counts only; a same-cycle commit never unblocks.
    always_comb begin
        need_alloc = has_dest && (dr != '0);
        in_ready   = !(out_valid && !out_ready)
                     && (rob_count != ROB_FULL)
                     && !(need_alloc && (fl_count == '0));
        accept     = in_valid && in_ready;
        do_alloc   = accept && need_alloc;
        fl_push    = commit_valid && commit_has_dest && (commit_old_preg != '0);
        alloc_preg = fl_mem[fl_head];
        src1_p     = rat[sr1];
        src2_p     = rat[sr2];
        src1_rdy   = (sr1 == '0) || ready_tbl[src1_p] || (wb_valid && (wb_preg == src1_p));
        src2_rdy   = (sr2 == '0) || ready_tbl[src2_p] || (wb_valid && (wb_preg == src2_p));
    end

    // NOTE: the RAT, ready table and free-list storage are reset explicitly because their
    // reset contents (identity map, all ready, ascending free regs) are architecturally visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PREG_W'(i);
            for (int i = 0; i < FL_DEPTH; i++) fl_mem[i] <= PREG_W'(ARCH_REGS + i);
            ready_tbl <= '1;
            fl_head   <= '0;
            fl_tail   <= '0;
            fl_count  <= FL_FULL;
            rob_tail  <= '0;
            rob_count <= '0;
            out_valid <= 1'b0;
            sr1_p     <= '0;
            sr2_p     <= '0;
            dr_p      <= '0;
            old_dr_p  <= '0;
            s1_ready  <= 1'b0;
            s2_ready  <= 1'b0;
            aluOp_out <= '0;
            imm_out   <= '0;
            ROB_num   <= '0;
        end else begin
            if (wb_valid && (wb_preg != '0)) ready_tbl[wb_preg] <= 1'b1;

            if (accept) begin
                out_valid <= 1'b1;
                sr1_p     <= src1_p;
                sr2_p     <= src2_p;
                s1_ready  <= src1_rdy;
                s2_ready  <= src2_rdy;
                dr_p      <= need_alloc ? alloc_preg : '0;
                old_dr_p  <= need_alloc ? rat[dr] : '0;
                aluOp_out <= aluOp;
                imm_out   <= imm;
                ROB_num   <= rob_tail;
                rob_tail  <= rob_tail + ROB_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // NOTE: placed after the wakeup write so the allocation clear wins on the same preg.
            if (do_alloc) begin
                rat[dr]               <= alloc_preg;
                ready_tbl[alloc_preg] <= 1'b0;
                fl_head               <= fl_next(fl_head);
            end

            if (fl_push) begin
                fl_mem[fl_tail] <= commit_old_preg;
                fl_tail         <= fl_next(fl_tail);
            end

            case ({do_alloc, fl_push})
                2'b10:   fl_count <= fl_count - (FL_W + 1)'(1);
                2'b01:   fl_count <= fl_count + (FL_W + 1)'(1);
                default: ;
            endcase

            case ({accept, commit_valid})
                2'b10:   rob_count <= rob_count + (ROB_W + 1)'(1);
                2'b01:   rob_count <= rob_count - (ROB_W + 1)'(1);
                default: ;
            endcase

            if (fl_push) assert (fl_count != FL_FULL) else $error("rename_unit: free-list overflow");
            if (commit_valid) assert (rob_count != '0) else $error("rename_unit: rob_count underflow");
        end
    end

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: directed scenarios plus randomized traffic, all scored against
// a queue/array reference model of the rename rules.
module tb_rename_unit;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int ROB_DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  sr1, sr2, dr;
    logic        has_dest;
    logic [3:0]  aluOp;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  sr1_p, sr2_p, dr_p, old_dr_p;
    logic        s1_ready, s2_ready;
    logic [3:0]  aluOp_out;
    logic [31:0] imm_out;
    logic [3:0]  ROB_num;
    logic        wb_valid;
    logic [5:0]  wb_preg;
    logic        commit_valid;
    logic        commit_has_dest;
    logic [5:0]  commit_old_preg;

    rename_unit #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .ROB_DEPTH(ROB_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sr1(sr1), .sr2(sr2), .dr(dr), .has_dest(has_dest), .aluOp(aluOp), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .sr1_p(sr1_p), .sr2_p(sr2_p), .dr_p(dr_p), .old_dr_p(old_dr_p),
        .s1_ready(s1_ready), .s2_ready(s2_ready), .aluOp_out(aluOp_out), .imm_out(imm_out),
        .ROB_num(ROB_num), .wb_valid(wb_valid), .wb_preg(wb_preg),
        .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
        .commit_old_preg(commit_old_preg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural map, ready flags, free-register queue, ROB occupancy.
    typedef struct {bit hd; int old;} inflight_t;
    int          rat_m [ARCH_REGS];
    bit          rdy_m [PHYS_REGS];
    int          free_q[$];
    inflight_t   infl_q[$];
    int          rob_tail_m, rob_cnt_m;
    bit          e_valid, e_s1, e_s2;
    int          e_sr1, e_sr2, e_dr, e_old, e_rob, e_alu;
    logic [31:0] e_imm;
    bit          last_acc;
    int          n_acc;

    function automatic void model_reset();
        for (int i = 0; i < ARCH_REGS; i++) rat_m[i] = i;
        for (int i = 0; i < PHYS_REGS; i++) rdy_m[i] = 1'b1;
        free_q.delete();
        for (int p = ARCH_REGS; p < PHYS_REGS; p++) free_q.push_back(p);
        infl_q.delete();
        rob_tail_m = 0; rob_cnt_m = 0;
        e_valid = 0; e_s1 = 0; e_s2 = 0;
        e_sr1 = 0; e_sr2 = 0; e_dr = 0; e_old = 0; e_rob = 0; e_alu = 0; e_imm = '0;
    endfunction

    task automatic idle_inputs();
        in_valid = 0; sr1 = '0; sr2 = '0; dr = '0; has_dest = 0; aluOp = '0; imm = '0;
        out_ready = 1; wb_valid = 0; wb_preg = '0;
        commit_valid = 0; commit_has_dest = 0; commit_old_preg = '0;
    endtask

    task automatic drive(input int s1, input int s2, input int d, input bit hd);
        in_valid = 1; sr1 = 5'(s1); sr2 = 5'(s2); dr = 5'(d); has_dest = hd;
        aluOp = 4'($urandom_range(0, 15)); imm = $urandom;
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check registered outputs after the edge.
    task automatic step();
        bit need, exp_rdy;
        int np;
        @(negedge clk);
        need    = has_dest && (dr != 0);
        exp_rdy = !(e_valid && !out_ready) && (rob_cnt_m != ROB_DEPTH) && !(need && free_q.size() == 0);
        check("in_ready", in_ready, exp_rdy);
        last_acc = 0;
        if (rst) begin
            model_reset();
        end else begin
            last_acc = in_valid && exp_rdy;
            if (last_acc) begin
                e_valid = 1;
                e_sr1 = rat_m[sr1];
                e_sr2 = rat_m[sr2];
                e_s1  = (sr1 == 0) || rdy_m[e_sr1] || (wb_valid && wb_preg == 6'(e_sr1));
                e_s2  = (sr2 == 0) || rdy_m[e_sr2] || (wb_valid && wb_preg == 6'(e_sr2));
                e_dr  = need ? free_q[0] : 0;
                e_old = need ? rat_m[dr] : 0;
                e_alu = aluOp; e_imm = imm;
                e_rob = rob_tail_m;
                rob_tail_m = (rob_tail_m + 1) % ROB_DEPTH;
            end else if (out_ready) begin
                e_valid = 0;
            end
            if (wb_valid && wb_preg != 0) rdy_m[wb_preg] = 1'b1;
            if (last_acc && need) begin
                np = free_q.pop_front();
                rat_m[dr] = np;
                rdy_m[np] = 1'b0;
            end
            if (commit_valid) begin
                void'(infl_q.pop_front());
                rob_cnt_m--;
                if (commit_has_dest && commit_old_preg != 0) free_q.push_back(int'(commit_old_preg));
            end
            if (last_acc) begin
                rob_cnt_m++;
                infl_q.push_back('{need, e_old});
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, e_valid);
        check("sr1_p", sr1_p, e_sr1);
        check("sr2_p", sr2_p, e_sr2);
        check("dr_p", dr_p, e_dr);
        check("old_dr_p", old_dr_p, e_old);
        check("s1_ready", s1_ready, e_s1);
        check("s2_ready", s2_ready, e_s2);
        check("aluOp_out", aluOp_out, e_alu);
        check("imm_out", imm_out, e_imm);
        check("ROB_num", ROB_num, e_rob);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        n_acc = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        model_reset();
        n_acc = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and first rename: add x3,x1,x2
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        drive(1, 2, 3, 1); step();
        check("add_sr1_p", sr1_p, 1);
        check("add_sr2_p", sr2_p, 2);
        check("add_dr_p", dr_p, 32);
        check("add_old_dr_p", old_dr_p, 3);
        check("add_ready", {30'd0, s1_ready, s2_ready}, 3);
        check("add_rob", ROB_num, 0);

        // Dependent sub x4,x3,x3, then a read of x3 bypassed by wb of p32
        drive(3, 3, 4, 1); step();
        check("sub_sr1_p", sr1_p, 32);
        check("sub_sr2_p", sr2_p, 32);
        check("sub_s1_ready", s1_ready, 0);
        check("sub_dr_p", dr_p, 33);
        drive(3, 0, 0, 0); wb_valid = 1; wb_preg = 6'd32; step();
        check("byp_sr1_p", sr1_p, 32);
        check("byp_s1_ready", s1_ready, 1);
        check("byp_dr_p", dr_p, 0);
        idle_inputs(); step();

        // ROB fills after 16 accepts; one commit reopens it and ROB_num wraps
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 1, 1); step();
            if (last_acc && n_acc == 16) check("rob_num_15", ROB_num, 15);
        end
        check("rob_full_accepts", n_acc, 16);
        check("rob_full_in_ready", in_ready, 0);
        commit_valid = 1; commit_has_dest = 1; commit_old_preg = 6'd1;
        step();
        commit_valid = 0; commit_has_dest = 0; commit_old_preg = '0;
        #1;
        check("rob_reopen_in_ready", in_ready, 1);
        step();
        check("rob_wrap", ROB_num, 0);

        // Free-list exhaustion: commits without destinations never return registers
        do_reset();
        for (int i = 0; i < 36; i++) begin
            drive($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31), 1);
            if (infl_q.size() > 0) begin
                commit_valid = 1; commit_has_dest = 0; commit_old_preg = 6'(infl_q[0].old);
            end else begin
                commit_valid = 0;
            end
            step();
        end
        commit_valid = 0; commit_old_preg = '0;
        check("fl_allocs", n_acc, 32);
        #1;
        check("fl_empty_in_ready", in_ready, 0);
        drive(1, 2, 5, 0);
        #1;
        check("fl_nodest_in_ready", in_ready, 1);
        step();
        check("fl_nodest_dr_p", dr_p, 0);
        drive(1, 2, 0, 1);
        #1;
        check("fl_x0_in_ready", in_ready, 1);
        step();
        check("fl_x0_dr_p", dr_p, 0);

        // Output hold for three cycles, then a single accept on release
        do_reset();
        drive(1, 2, 3, 1); step();
        drive(3, 1, 7, 1); out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_dr_p", dr_p, 32);
            check("hold_valid", out_valid, 1);
        end
        out_ready = 1; step();
        check("release_dr_p", dr_p, 33);
        check("release_rob", ROB_num, 1);
        idle_inputs(); step();
        check("release_single", out_valid, 0);

        // Reset in the middle of traffic
        drive(1, 2, 3, 1); step();
        drive(2, 3, 9, 1); step();
        rst = 1; drive(4, 5, 6, 1); step(); rst = 0;
        check("midrst_out_valid", out_valid, 0);
        drive(1, 2, 3, 1); step();
        check("midrst_dr_p", dr_p, 32);
        check("midrst_rob", ROB_num, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            sr1       = 5'($urandom_range(0, 31));
            sr2       = 5'($urandom_range(0, 31));
            dr        = 5'($urandom_range(0, 31));
            has_dest  = ($urandom_range(0, 3) != 0);
            aluOp     = 4'($urandom_range(0, 15));
            imm       = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            commit_valid = 0; commit_has_dest = 0; commit_old_preg = '0;
            if (infl_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                commit_valid    = 1;
                commit_has_dest = infl_q[0].hd && ($urandom_range(0, 9) != 0);
                commit_old_preg = 6'(infl_q[0].old);
            end
            wb_valid = ($urandom_range(0, 1) == 1);
            wb_preg  = 6'($urandom_range(0, 63));
            if (free_q.size() > 0 && int'(wb_preg) == free_q[0]) wb_valid = 0;
            step();
        end
        rst = 0;
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
